axi4l_reg_slave: RTL and testbench

AXI4L_REG_SLAVE -- requirements
Module: axi4l_reg_slave

---
 rtl/axi4l_reg_slave_if.sv | 61 ++++++
 rtl/axi4l_reg_slave.sv | 177 +++++++++++++++++
 tb/tb_axi4l_reg_slave.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_reg_slave_if.sv
// AXI4-Lite slave bus bundled with the simple register request/ack port of axi4l_reg_slave.
// Latency: none (wires only).
// Backpressure: carried by the AXI READY/VALID pairs and the level reg_req / pulse reg_ack pair.
// Ports: AW/W/B/AR/R channels use lowercase AXI names; reg_* is the register-file side.
// Modport slave = the bridge; modport master = AXI master plus register-file responder.
interface axi4l_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic                  reg_req;
    logic                  reg_wr;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [3:0]            reg_wstrb;
    logic                  reg_ack;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  reg_err;

    modport slave (
        input  awaddr, awcache, awprot, awvalid,
        input  wdata, wstrb, wvalid,
        input  bready,
        input  araddr, arcache, arprot, arvalid,
        input  rready,
        input  reg_ack, reg_rdata, reg_err,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb
    );

    modport master (
        output awaddr, awcache, awprot, awvalid,
        output wdata, wstrb, wvalid,
        output bready,
        output araddr, arcache, arprot, arvalid,
        output rready,
        output reg_ack, reg_rdata, reg_err,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb
    );
endinterface

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite slave that turns each access into a level reg_req / pulse reg_ack register access.
// Latency: last AW/W or AR handshake in cycle N -> reg_req high in N+2; reg_ack in M -> B/R valid in M+1.
// Backpressure: one access in flight; each channel READY drops while its holding register is full,
// B/R are held until BREADY/RREADY; a silent register file is cut off after TIMEOUT cycles with SLVERR.
// Ports: aclk, aresetn (async active-low), bus (axi4l_reg_slave_if.slave: AXI channels + reg_* port).
module axi4l_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi4l_reg_slave_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t                state;
    logic                  rdy_en;      // keeps all READYs low until the first edge after reset release
    logic                  aw_held;
    logic                  w_held;
    logic                  ar_held;
    logic                  rr_ptr;      // 0: write wins a tie, 1: read wins a tie
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;
    logic [15:0]           tmo_cnt;

    logic                  hs_aw;
    logic                  hs_w;
    logic                  hs_ar;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  timeout;
    logic [1:0]            ack_resp;
    logic [DATA_WIDTH-1:0] ack_rdata;
    logic                  unused_ok;

    assign bus.awready = rdy_en & ~aw_held;
    assign bus.wready  = rdy_en & ~w_held;
    assign bus.arready = rdy_en & ~ar_held;

    assign hs_aw = bus.awvalid & bus.awready;
    assign hs_w  = bus.wvalid  & bus.wready;
    assign hs_ar = bus.arvalid & bus.arready;

    assign wr_elig  = aw_held & w_held;
    assign rd_elig  = ar_held;
    assign grant_wr = wr_elig & (~rd_elig | ~rr_ptr);
    assign grant_rd = rd_elig & ~grant_wr;

    // TIMEOUT reg_req-high cycles have elapsed once the count reaches TIMEOUT-1;
    // an ack in that same last cycle still wins.
    assign timeout   = (tmo_cnt == TMO_LAST);
    assign ack_resp  = bus.reg_err ? RESP_SLVERR : RESP_OKAY;
    assign ack_rdata = bus.reg_err ? '0 : bus.reg_rdata;

    // Cache/prot attributes and the byte offset of the addresses carry no meaning here.
    assign unused_ok = ^{bus.awcache, bus.arcache, bus.awprot, bus.arprot,
                         bus.awaddr[1:0], bus.araddr[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rdy_en        <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            ar_held       <= 1'b0;
            rr_ptr        <= 1'b0;
            aw_addr_q     <= '0;
            ar_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            tmo_cnt       <= '0;
            bus.reg_req   <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wstrb <= '0;
            bus.bvalid    <= 1'b0;
            bus.bresp     <= RESP_OKAY;
            bus.rvalid    <= 1'b0;
            bus.rresp     <= RESP_OKAY;
            bus.rdata     <= '0;
        end else begin
            rdy_en <= 1'b1;

            // Channel capture. A held channel has READY low, so capture never
            // coincides with the release done by the FSM below.
            if (hs_aw) begin
                aw_held   <= 1'b1;
                aw_addr_q <= {bus.awaddr[ADDR_WIDTH-1:2], 2'b00};
            end
            if (hs_w) begin
                w_held   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            if (hs_ar) begin
                ar_held   <= 1'b1;
                ar_addr_q <= {bus.araddr[ADDR_WIDTH-1:2], 2'b00};
            end

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_wr) begin
                        state         <= WR_REQ;
                        rr_ptr        <= ~rr_ptr;
                        bus.reg_req   <= 1'b1;
                        bus.reg_wr    <= 1'b1;
                        bus.reg_addr  <= aw_addr_q;
                        bus.reg_wdata <= w_data_q;
                        bus.reg_wstrb <= w_strb_q;
                    end else if (grant_rd) begin
                        state        <= RD_REQ;
                        rr_ptr       <= ~rr_ptr;
                        bus.reg_req  <= 1'b1;
                        bus.reg_wr   <= 1'b0;
                        bus.reg_addr <= ar_addr_q;
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (bus.reg_ack || timeout) begin
                        bus.reg_req <= 1'b0;
                        bus.reg_wr  <= 1'b0;
                        if (state == WR_REQ) begin
                            state      <= WR_RESP;
                            bus.bvalid <= 1'b1;
                            bus.bresp  <= bus.reg_ack ? ack_resp : RESP_SLVERR;
                        end else begin
                            state      <= RD_RESP;
                            bus.rvalid <= 1'b1;
                            bus.rresp  <= bus.reg_ack ? ack_resp : RESP_SLVERR;
                            bus.rdata  <= bus.reg_ack ? ack_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                // reg_ack is not looked at in the response states, so a late ack is dropped.
                WR_RESP: begin
                    if (bus.bready) begin
                        state      <= IDLE;
                        bus.bvalid <= 1'b0;
                        aw_held    <= 1'b0;
                        w_held     <= 1'b0;
                    end
                end

                RD_RESP: begin
                    if (bus.rready) begin
                        state      <= IDLE;
                        bus.rvalid <= 1'b0;
                        ar_held    <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Self-checking bench for axi4l_reg_slave: directed scenarios plus randomized single accesses
// compared against a response model derived from the access rules (timeout, error, latency).
module tb_axi4l_reg_slave;
    localparam int TMO = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 aclk = ~aclk;

    axi4l_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4l_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT   (TMO)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    typedef struct packed {
        int          lat;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          req_cyc;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        vld_first;
        logic        stable;
        logic        vld_after;
        logic        rdy_back;
    } obs_t;

    // Step to 1 time unit after the next rising edge: outputs are sampled and inputs driven here.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Reference model: the access response follows from when (if ever) the ack arrives.
    function automatic logic [1:0] exp_resp(input int ack_dly, input bit err);
        if (ack_dly >= TMO) return 2'b10;
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic int exp_req_cycles(input int ack_dly);
        return (ack_dly >= TMO) ? TMO : ack_dly + 1;
    endfunction

    // Drives one complete access and reports what the DUT did.
    // lead > 0: W presented lead cycles before AW; lead < 0: AW first; ack_dly: reg_req cycle
    // index of the ack (0 = first); rdy_dly: cycles BREADY/RREADY are held low.
    task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int ack_dly, input bit err,
                          input logic [31:0] rd_in, input int rdy_dly, output obs_t o);
        int t_a, t_w, t, i;
        bit done_a, done_w, hs_a, hs_w, late;
        o      = '0;
        t_a    = (lead > 0) ? lead : 0;
        t_w    = (lead < 0) ? -lead : 0;
        done_a = 1'b0;
        done_w = !is_wr;
        t      = 0;
        while (!(done_a && done_w) && t < 50) begin
            if (is_wr) begin
                if (t == t_a && !done_a) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
                if (t == t_w && !done_w) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
                hs_a = bus.awvalid && bus.awready;
                hs_w = bus.wvalid && bus.wready;
            end else begin
                if (t == 0) begin bus.araddr = addr; bus.arvalid = 1'b1; end
                hs_a = bus.arvalid && bus.arready;
                hs_w = 1'b0;
            end
            cyc();
            if (hs_a) begin done_a = 1'b1; bus.awvalid = 1'b0; bus.arvalid = 1'b0; end
            if (hs_w) begin done_w = 1'b1; bus.wvalid = 1'b0; end
            t++;
        end
        o.lat = 1;
        while (bus.reg_req !== 1'b1 && o.lat < 20) begin cyc(); o.lat++; end
        o.addr  = bus.reg_addr;
        o.wr    = bus.reg_wr;
        o.wdata = bus.reg_wdata;
        o.strb  = bus.reg_wstrb;
        i = 0;
        while (bus.reg_req === 1'b1 && i < 50) begin
            if (i == ack_dly) begin bus.reg_ack = 1'b1; bus.reg_err = err; bus.reg_rdata = rd_in; end
            cyc();
            bus.reg_ack = 1'b0; bus.reg_err = 1'b0; bus.reg_rdata = '0;
            i++;
        end
        o.req_cyc   = i;
        late        = (ack_dly >= i);
        o.vld_first = is_wr ? bus.bvalid : bus.rvalid;
        o.resp      = is_wr ? bus.bresp : bus.rresp;
        o.rdata     = bus.rdata;
        o.stable    = 1'b1;
        // An ack that never landed inside reg_req is sent now; it must change nothing.
        if (late) begin bus.reg_ack = 1'b1; bus.reg_err = 1'b0; bus.reg_rdata = 32'hFFFF_FFFF; end
        for (int j = 0; j < rdy_dly; j++) begin
            cyc();
            bus.reg_ack = 1'b0; bus.reg_rdata = '0;
            if ((is_wr ? bus.bvalid : bus.rvalid) !== 1'b1 ||
                (is_wr ? bus.bresp : bus.rresp) !== o.resp || bus.rdata !== o.rdata)
                o.stable = 1'b0;
        end
        if (is_wr) bus.bready = 1'b1; else bus.rready = 1'b1;
        cyc();
        bus.reg_ack = 1'b0; bus.reg_rdata = '0; bus.bready = 1'b0; bus.rready = 1'b0;
        o.vld_after = is_wr ? bus.bvalid : bus.rvalid;
        o.rdy_back  = is_wr ? (bus.awready & bus.wready) : bus.arready;
    endtask

    task automatic test_reset();
        logic [6:0]  ctl;
        logic [35:0] dat;
        aresetn = 1'b0;
        cyc();
        ctl = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.reg_req, bus.reg_wr};
        total++; if (ctl !== 7'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=0", ctl); end
        dat = {bus.bresp, bus.rresp, bus.rdata};
        total++; if (dat !== 36'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", dat); end
        aresetn = 1'b1;
        total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b exp=0", bus.awready); end
        cyc();
        ctl[2:0] = {bus.awready, bus.wready, bus.arready};
        total++; if (ctl[2:0] !== 3'b111) begin bad++; $display("FAIL rst_ready_rise got=%b exp=111", ctl[2:0]); end
    endtask

    // Entered straight from reset: both directions eligible together, write must win.
    task automatic test_arbitration();
        int n;
        bit stable;
        bus.awaddr = 32'h44; bus.wdata = 32'h1111_2222; bus.wstrb = 4'h3;
        bus.araddr = 32'h88;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n = 0;
        while (bus.reg_req !== 1'b1 && n < 10) begin cyc(); n++; end
        total++; if ({bus.reg_req, bus.reg_wr, bus.reg_addr} !== {2'b11, 32'h44})
            begin bad++; $display("FAIL arb_first req=%b wr=%b addr=%h exp req=1 wr=1 addr=44", bus.reg_req, bus.reg_wr, bus.reg_addr); end
        total++; if (bus.arready !== 1'b0) begin bad++; $display("FAIL arb_ar_held got=%b exp=0", bus.arready); end
        bus.reg_ack = 1'b1;
        cyc();
        bus.reg_ack = 1'b0;
        total++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin bad++; $display("FAIL arb_b got=%b exp=100", {bus.bvalid, bus.bresp}); end
        bus.bready = 1'b1;
        cyc();
        bus.bready = 1'b0;
        n = 0;
        while (bus.reg_req !== 1'b1 && n < 10) begin cyc(); n++; end
        total++; if ({bus.reg_req, bus.reg_wr, bus.reg_addr} !== {2'b10, 32'h88})
            begin bad++; $display("FAIL arb_second req=%b wr=%b addr=%h exp req=1 wr=0 addr=88", bus.reg_req, bus.reg_wr, bus.reg_addr); end
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'hCAFE_F00D;
        cyc();
        bus.reg_ack = 1'b0; bus.reg_rdata = '0;
        stable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if ({bus.rvalid, bus.rresp, bus.rdata} !== {3'b100, 32'hCAFE_F00D}) stable = 1'b0;
            cyc();
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL arb_r_stable got=%b exp=1", stable); end
        bus.rready = 1'b1;
        cyc();
        bus.rready = 1'b0;
        total++; if ({bus.rvalid, bus.arready} !== 2'b01) begin bad++; $display("FAIL arb_r_done got=%b exp=01", {bus.rvalid, bus.arready}); end
    endtask

    task automatic test_write_basic();
        obs_t o;
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 2, 1'b0, 32'h0, 1, o);
        total++; if (o.lat !== 2) begin bad++; $display("FAIL wr_lat got=%0d exp=2", o.lat); end
        total++; if ({o.addr, o.wr} !== {32'h10, 1'b1}) begin bad++; $display("FAIL wr_addr got=%h/%b exp=10/1", o.addr, o.wr); end
        total++; if ({o.wdata, o.strb} !== {32'hDEAD_BEEF, 4'hF}) begin bad++; $display("FAIL wr_data got=%h/%h exp=deadbeef/f", o.wdata, o.strb); end
        total++; if (o.req_cyc !== 3) begin bad++; $display("FAIL wr_req_cyc got=%0d exp=3", o.req_cyc); end
        total++; if (o.resp !== 2'b00) begin bad++; $display("FAIL wr_bresp got=%b exp=00", o.resp); end
        total++; if ({o.vld_first, o.vld_after, o.rdy_back} !== 3'b101) begin bad++; $display("FAIL wr_one_beat got=%b exp=101", {o.vld_first, o.vld_after, o.rdy_back}); end
    endtask

    task automatic test_w_before_aw();
        obs_t o;
        access(1'b1, 32'h13, 32'h0BAD_F00D, 4'h5, 2, 0, 1'b0, 32'h0, 0, o);
        total++; if (o.lat !== 2) begin bad++; $display("FAIL wfirst_lat got=%0d exp=2", o.lat); end
        total++; if (o.addr !== 32'h10) begin bad++; $display("FAIL wfirst_addr got=%h exp=10", o.addr); end
        total++; if ({o.wdata, o.strb} !== {32'h0BAD_F00D, 4'h5}) begin bad++; $display("FAIL wfirst_data got=%h/%h exp=0badf00d/5", o.wdata, o.strb); end
    endtask

    task automatic test_read_err();
        obs_t o;
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, 1, 1'b1, 32'h1234_5678, 2, o);
        total++; if ({o.addr, o.wr} !== {32'h20, 1'b0}) begin bad++; $display("FAIL rderr_addr got=%h/%b exp=20/0", o.addr, o.wr); end
        total++; if ({o.resp, o.rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL rderr_resp got=%b/%h exp=10/0", o.resp, o.rdata); end
        total++; if ({o.stable, o.vld_after, o.rdy_back} !== 3'b101) begin bad++; $display("FAIL rderr_done got=%b exp=101", {o.stable, o.vld_after, o.rdy_back}); end
    endtask

    task automatic test_timeout();
        obs_t o;
        access(1'b1, 32'h30, 32'h5555_AAAA, 4'hC, 0, 10, 1'b0, 32'h0, 3, o);
        total++; if (o.req_cyc !== TMO) begin bad++; $display("FAIL tmo_wr_cyc got=%0d exp=%0d", o.req_cyc, TMO); end
        total++; if ({o.resp, o.stable} !== 3'b101) begin bad++; $display("FAIL tmo_wr_resp got=%b/%b exp=10/1", o.resp, o.stable); end
        access(1'b0, 32'h34, 32'h0, 4'h0, 0, 10, 1'b0, 32'h7777_7777, 3, o);
        total++; if (o.req_cyc !== TMO) begin bad++; $display("FAIL tmo_rd_cyc got=%0d exp=%0d", o.req_cyc, TMO); end
        total++; if ({o.resp, o.rdata, o.stable} !== {2'b10, 32'h0, 1'b1}) begin bad++; $display("FAIL tmo_rd_resp got=%b/%h/%b exp=10/0/1", o.resp, o.rdata, o.stable); end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          is_wr, err;
        logic [31:0] addr, data, rd;
        logic [3:0]  strb;
        logic [1:0]  er;
        int          lead, ack, rdy;
        for (int k = 0; k < 30; k++) begin
            is_wr = 1'($urandom_range(1, 0));
            addr  = $urandom;
            data  = $urandom;
            rd    = $urandom;
            strb  = 4'($urandom_range(15, 0));
            lead  = int'($urandom_range(6, 0)) - 3;
            ack   = int'($urandom_range(5, 0));
            err   = 1'($urandom_range(1, 0));
            rdy   = int'($urandom_range(3, 0));
            access(is_wr, addr, data, strb, lead, ack, err, rd, rdy, o);
            er = exp_resp(ack, err);
            total++; if (o.lat !== 2) begin bad++; $display("FAIL rnd%0d_lat got=%0d exp=2", k, o.lat); end
            total++; if ({o.addr, o.wr} !== {addr & 32'hFFFF_FFFC, is_wr})
                begin bad++; $display("FAIL rnd%0d_addr got=%h/%b exp=%h/%b", k, o.addr, o.wr, addr & 32'hFFFF_FFFC, is_wr); end
            if (is_wr) begin
                total++; if ({o.wdata, o.strb} !== {data, strb}) begin bad++; $display("FAIL rnd%0d_wdata got=%h/%h exp=%h/%h", k, o.wdata, o.strb, data, strb); end
            end else begin
                total++; if (o.rdata !== ((er == 2'b00) ? rd : 32'h0)) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, o.rdata, (er == 2'b00) ? rd : 32'h0); end
            end
            total++; if (o.req_cyc !== exp_req_cycles(ack)) begin bad++; $display("FAIL rnd%0d_req_cyc got=%0d exp=%0d", k, o.req_cyc, exp_req_cycles(ack)); end
            total++; if (o.resp !== er) begin bad++; $display("FAIL rnd%0d_resp got=%b exp=%b", k, o.resp, er); end
            total++; if ({o.vld_first, o.stable, o.vld_after, o.rdy_back} !== 4'b1101)
                begin bad++; $display("FAIL rnd%0d_handshake got=%b exp=1101", k, {o.vld_first, o.stable, o.vld_after, o.rdy_back}); end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        int   n;
        bus.araddr = 32'h5C; bus.arvalid = 1'b1;
        cyc();
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.reg_req !== 1'b1 && n < 10) begin cyc(); n++; end
        total++; if (bus.reg_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_seen got=%b exp=1", bus.reg_req); end
        #3;
        aresetn = 1'b0;
        #1;
        total++; if ({bus.reg_req, bus.rvalid, bus.arready} !== 3'b000)
            begin bad++; $display("FAIL rstmid_async got=%b exp=000", {bus.reg_req, bus.rvalid, bus.arready}); end
        cyc();
        aresetn = 1'b1;
        cyc();
        access(1'b0, 32'h64, 32'h0, 4'h0, 0, 0, 1'b0, 32'hA5A5_0F0F, 1, o);
        total++; if ({o.addr, o.wr} !== {32'h64, 1'b0}) begin bad++; $display("FAIL rstmid_addr got=%h/%b exp=64/0", o.addr, o.wr); end
        total++; if ({o.resp, o.rdata} !== {2'b00, 32'hA5A5_0F0F}) begin bad++; $display("FAIL rstmid_read got=%b/%h exp=00/a5a50f0f", o.resp, o.rdata); end
    endtask

    initial begin
        bus.awaddr = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0; bus.reg_ack = 1'b0; bus.reg_rdata = '0; bus.reg_err = 1'b0;
        aresetn = 1'b0;
        repeat (3) cyc();
        test_reset();
        test_arbitration();
        test_write_basic();
        test_w_before_aw();
        test_read_err();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
